wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter CNT_W, default 32, width of retire counter.
REQ-002 clk  in  1  rising-edge clock, sole clock.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 mem_valid  in  1  MEM stage holds a valid instruction.
REQ-005 mem_reg_we  in  1  instruction writes rd.
REQ-006 mem_rd  in  5  destination register.
REQ-007 mem_wb_sel  in  2  00 ALU result, 01 load, 10 PC+4, 11 immediate (LUI).
REQ-008 mem_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-009 mem_alu_result  in  32  ALU result; for loads, the byte address.
REQ-010 mem_load_word  in  32  raw aligned 32-bit word from data memory.
REQ-011 mem_pc4  in  32  PC+4 of instruction.
REQ-012 mem_imm  in  32  U-type immediate.
REQ-013 stall  in  1  hold WB register contents.
REQ-014 flush  in  1  kill instruction entering WB.
REQ-015 WE  out  1  register-file write enable.
REQ-016 AddD  out  5  register-file write address.
REQ-017 DataD  out  32  register-file write data.
REQ-018 fwd_valid  out  1  WB result available for forwarding to EX.
REQ-019 load_misalign  out  1  misaligned load in WB, write suppressed.
REQ-020 retire_count  out  CNT_W  retired-instruction count.

Function
REQ-021 One MEM/WB pipeline register SHALL hold valid, reg_we, rd, wb_sel, funct3, alu_result, load_word, pc4, imm, plus a first-cycle flag.
REQ-022 Update priority at posedge clk SHALL be: rst low > flush > stall > capture.
REQ-023 Flush SHALL clear valid (bubble); other fields don't-care.
REQ-024 Stall SHALL hold all fields and clear the first-cycle flag.
REQ-025 Capture SHALL load all MEM inputs and set first-cycle flag to 1.
REQ-026 Load extraction SHALL use byte offset alu_result[1:0]: LB/LBU select byte at offset, LH/LHU halfword at offset[1], LW whole word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-027 load_misalign SHALL be 1 when valid, wb_sel=01, and (LH/LHU with offset[0]=1, or LW with offset!=0); else 0.
REQ-028 Undefined funct3 on load SHALL yield DataD as LW result.
REQ-029 DataD SHALL be combinational from registered fields per wb_sel.
REQ-030 AddD SHALL equal registered rd at all times.
REQ-031 WE SHALL equal valid & first & reg_we & (rd!=0) & !load_misalign; a held (stalled) instruction SHALL write only once.
REQ-032 fwd_valid SHALL equal valid & reg_we & (rd!=0) & !load_misalign, independent of first-cycle flag.
REQ-033 retire_count SHALL increment by 1 on a clock edge where valid & first is 1 (including misaligned and rd=0 instructions), wrapping modulo 2^CNT_W.
REQ-034 Combinational path from any input to any output SHALL NOT exist; latency MEM-to-WE is 1 cycle.

Reset
REQ-035 With rst low at a rising edge, valid, first, and retire_count SHALL clear to 0, overriding flush and stall.
REQ-036 During and after reset until first capture: WE=0, fwd_valid=0, load_misalign=0, retire_count=0; AddD/DataD derived from cleared fields (0).
REQ-037 Reset asserted mid-stall SHALL discard the held instruction with no write.

Verification
REQ-038 ALU: mem_valid=1, reg_we=1, rd=5, wb_sel=00, alu_result=0x1234_5678 -> next cycle WE=1, AddD=5, DataD=0x1234_5678, retire_count=1.
REQ-039 LB/LBU: load_word=0x80FF_7F01, alu_result=...03, funct3=000 -> DataD=0xFFFF_FF80; funct3=100 -> 0x0000_0080.
REQ-040 Misalign: LW with alu_result=0x1002 -> load_misalign=1, WE=0, fwd_valid=0, retire_count increments.
REQ-041 Stall 3 cycles after capture rd=7 -> WE=1 first cycle only, fwd_valid=1 all 4 cycles, retire_count +1.
REQ-042 flush and stall both high with mem_valid=1 -> next cycle valid=0, WE=0; rd=0 write -> WE=0, retire_count +1.
REQ-043 retire_count preloaded via 2^CNT_W-1 retirements (CNT_W=4 build: 15) then one more -> 0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load extraction, and register-file write
// generation with single-write-per-instruction semantics under stall, plus a retire counter.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_reg_we,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_funct3,
  input  logic [31:0]      mem_alu_result,
  input  logic [31:0]      mem_load_word,
  input  logic [31:0]      mem_pc4,
  input  logic [31:0]      mem_imm,
  input  logic             stall,
  input  logic             flush,
  output logic             WE,
  output logic [4:0]       AddD,
  output logic [31:0]      DataD,
  output logic             fwd_valid,
  output logic             load_misalign,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_LD  = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;

  logic             r_valid, r_first, r_reg_we;
  logic [4:0]       r_rd;
  logic [1:0]       r_wb_sel;
  logic [2:0]       r_funct3;
  logic [31:0]      r_alu, r_ldw, r_pc4, r_imm;
  logic [CNT_W-1:0] r_cnt;

  // r_first marks the single cycle in which a held instruction may write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_first  <= 1'b0;
      r_reg_we <= 1'b0;
      r_rd     <= '0;
      r_wb_sel <= '0;
      r_funct3 <= '0;
      r_alu    <= '0;
      r_ldw    <= '0;
      r_pc4    <= '0;
      r_imm    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_first <= 1'b0;
    end else if (stall) begin
      r_first <= 1'b0;
    end else begin
      r_valid  <= mem_valid;
      r_first  <= 1'b1;
      r_reg_we <= mem_reg_we;
      r_rd     <= mem_rd;
      r_wb_sel <= mem_wb_sel;
      r_funct3 <= mem_funct3;
      r_alu    <= mem_alu_result;
      r_ldw    <= mem_load_word;
      r_pc4    <= mem_pc4;
      r_imm    <= mem_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                  r_cnt <= '0;
    else if (r_valid & r_first) r_cnt <= r_cnt + CNT_W'(1);
  end

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic        w_mis;
  logic        w_wr_ok;

  always_comb begin
    w_byte = r_ldw[7:0];
    case (r_alu[1:0])
      2'd1:    w_byte = r_ldw[15:8];
      2'd2:    w_byte = r_ldw[23:16];
      2'd3:    w_byte = r_ldw[31:24];
      default: w_byte = r_ldw[7:0];
    endcase
  end

  assign w_half = r_alu[1] ? r_ldw[31:16] : r_ldw[15:0];

  // Undefined load types fall back to the full word.
  always_comb begin
    w_load = r_ldw;
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = r_ldw;
    endcase
  end

  always_comb begin
    w_mis = 1'b0;
    if (r_valid && r_wb_sel == SEL_LD) begin
      case (r_funct3)
        3'b001, 3'b101: w_mis = r_alu[0];
        3'b010:         w_mis = (r_alu[1:0] != 2'd0);
        default:        w_mis = 1'b0;
      endcase
    end
  end

  always_comb begin
    DataD = r_imm;
    case (r_wb_sel)
      SEL_ALU: DataD = r_alu;
      SEL_LD:  DataD = w_load;
      SEL_PC4: DataD = r_pc4;
      default: DataD = r_imm;
    endcase
  end

  assign w_wr_ok       = r_valid & r_reg_we & (r_rd != 5'd0) & ~w_mis;
  assign WE            = w_wr_ok & r_first;
  assign fwd_valid     = w_wr_ok;
  assign AddD          = r_rd;
  assign load_misalign = w_mis;
  assign retire_count  = r_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized + directed bench for wb_stage; expected outputs come from an
// instruction-level model (one held instruction, a "not yet written" flag, an integer counter).
module tb_wb_stage;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_valid, mem_reg_we;
  logic [4:0]    mem_rd;
  logic [1:0]    mem_wb_sel;
  logic [2:0]    mem_funct3;
  logic [31:0]   mem_alu_result, mem_load_word, mem_pc4, mem_imm;
  logic          stall, flush;
  logic          WE, fwd_valid, load_misalign;
  logic [4:0]    AddD;
  logic [31:0]   DataD;
  logic [CW-1:0] retire_count;

  wb_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_we(mem_reg_we),
    .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_load_word(mem_load_word),
    .mem_pc4(mem_pc4), .mem_imm(mem_imm), .stall(stall), .flush(flush),
    .WE(WE), .AddD(AddD), .DataD(DataD), .fwd_valid(fwd_valid),
    .load_misalign(load_misalign), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v, we;
    int        rd, sel, f3;
    bit [31:0] alu, ldw, pc4, imm;
  } inst_t;

  inst_t m_i;
  bit    m_fresh;
  int    m_cnt;
  int    n_tot = 0, n_bad = 0;
  int    n_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_mis();
    int off = int'(m_i.alu % 4);
    if (!m_i.v || m_i.sel != 1) return 0;
    if (m_i.f3 == 1 || m_i.f3 == 5) return (off % 2) == 1;
    if (m_i.f3 == 2) return off != 0;
    return 0;
  endfunction

  function automatic bit [31:0] m_data();
    bit [31:0] b, h;
    int off = int'(m_i.alu % 4);
    b = (m_i.ldw >> (8 * off)) & 32'hFF;
    h = (m_i.ldw >> (16 * (off / 2))) & 32'hFFFF;
    case (m_i.sel)
      0: return m_i.alu;
      2: return m_i.pc4;
      3: return m_i.imm;
      default: case (m_i.f3)
        0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
        1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
        4: return b;
        5: return h;
        default: return m_i.ldw;
      endcase
    endcase
  endfunction

  // Apply one clock edge to the model using the current input values.
  task automatic model_edge();
    if (!rst) begin
      m_i = '{default: 0};
      m_fresh = 0;
      m_cnt = 0;
    end else begin
      if (m_i.v && m_fresh) m_cnt = (m_cnt + 1) % (1 << CW);
      if (flush) begin
        m_i.v = 0; m_fresh = 0;
      end else if (stall) begin
        m_fresh = 0;
      end else begin
        m_i = '{v: mem_valid, we: mem_reg_we, rd: int'(mem_rd), sel: int'(mem_wb_sel),
                f3: int'(mem_funct3), alu: mem_alu_result, ldw: mem_load_word,
                pc4: mem_pc4, imm: mem_imm};
        m_fresh = 1;
      end
    end
  endtask

  task automatic step();
    bit wr;
    @(posedge clk);
    model_edge();
    #1;
    wr = m_i.v && m_i.we && m_i.rd != 0 && !m_mis();
    chk("WE", 32'(WE), 32'(wr && m_fresh));
    chk("fwd_valid", 32'(fwd_valid), 32'(wr));
    chk("misalign", 32'(load_misalign), 32'(m_mis()));
    chk("AddD", 32'(AddD), 32'(m_i.rd));
    chk("DataD", DataD, m_data());
    chk("retire_count", 32'(retire_count), 32'(m_cnt));
    if (WE) n_wr++;
  endtask

  task automatic drv(input bit v, input bit we, input int rd, input int sel, input int f3,
                     input bit [31:0] alu, input bit [31:0] ldw);
    mem_valid = v; mem_reg_we = we; mem_rd = 5'(rd); mem_wb_sel = 2'(sel);
    mem_funct3 = 3'(f3); mem_alu_result = alu; mem_load_word = ldw;
    mem_pc4 = $urandom; mem_imm = $urandom;
    stall = 0; flush = 0; rst = 1;
  endtask

  initial begin
    m_i = '{default: 0}; m_fresh = 0; m_cnt = 0; n_wr = 0;
    drv(0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    step(); step();
    chk("rst_cnt", 32'(retire_count), 0);
    chk("rst_we", 32'(WE), 0);

    drv(1, 1, 5, 0, 0, 32'h1234_5678, 0); step();
    chk("alu_data", DataD, 32'h1234_5678);
    chk("alu_we", 32'(WE), 1);
    drv(1, 1, 3, 1, 0, 32'h0000_0003, 32'h80FF_7F01); step();
    chk("lb", DataD, 32'hFFFF_FF80);
    chk("alu_cnt", 32'(retire_count), 1);
    drv(1, 1, 3, 1, 4, 32'h0000_0003, 32'h80FF_7F01); step();
    chk("lbu", DataD, 32'h0000_0080);
    drv(1, 1, 9, 1, 2, 32'h0000_1002, 32'hDEAD_BEEF); step();
    chk("lw_mis", 32'(load_misalign), 1);
    chk("lw_mis_we", 32'(WE), 0);

    // Held instruction must write exactly once across the stall.
    drv(1, 1, 7, 0, 0, 32'hCAFE_0007, 0); step();
    n_wr = 0;
    if (WE) n_wr++;
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0); stall = 1; step();
      chk("stall_fwd", 32'(fwd_valid), 1);
    end
    chk("stall_writes", 32'(n_wr), 1);

    drv(1, 1, 11, 0, 0, 32'h1111_1111, 0); stall = 1; flush = 1; step();
    chk("flush_we", 32'(WE), 0);
    drv(1, 1, 0, 0, 0, 32'h2222_2222, 0); step();
    chk("rd0_we", 32'(WE), 0);

    // Reset during a stall discards the held instruction.
    drv(1, 1, 12, 0, 0, 32'h3333_3333, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0); stall = 1; rst = 0; step();
    chk("rst_stall_we", 32'(WE), 0);

    // Counter wrap: 16 retirements from reset.
    drv(0, 0, 0, 0, 0, 0, 0); rst = 0; step();
    for (int i = 0; i < 16; i++) begin
      drv(1, 1, 1 + i, 0, 0, $urandom, 0); step();
    end
    chk("cnt_15", 32'(retire_count), 15);
    drv(0, 0, 0, 0, 0, 0, 0); step();
    chk("cnt_wrap", 32'(retire_count), 0);

    for (int i = 0; i < 1500; i++) begin
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31),
          $urandom_range(0, 3),
          ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 5),
          $urandom, $urandom);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 49) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
